ldpc_forest_scheduler: RTL and testbench

// - Sequencer driving the 8-input LDPC mux forest: walks a programmable base-matrix entry table and, per beat,

---
 rtl/ldpc_forest_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_ldpc_forest_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_forest_scheduler.sv
// Beat sequencer for the 8-input LDPC mux forest. It walks a programmable base-matrix entry table
// and, on each beat, issues 8 lanes of {row offset, RAM index, branch} for one expansion row.
module ldpc_forest_scheduler #(
  parameter int unsigned NUM_RAMS         = 24,
  parameter int unsigned EXPANSION_FACTOR = 96,
  parameter int unsigned MAX_ENTRIES      = 64,
  parameter int unsigned LANES            = 8,
  localparam int unsigned RW = $clog2(NUM_RAMS),
  localparam int unsigned OW = $clog2(EXPANSION_FACTOR),
  localparam int unsigned AW = $clog2(MAX_ENTRIES),
  localparam int unsigned BW = 3,
  localparam int unsigned DW = RW + OW + BW
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cfg_we,
  input  logic [AW-1:0]       i_cfg_addr,
  input  logic [DW-1:0]       i_cfg_data,
  output logic                o_cfg_err,
  input  logic [AW:0]         i_num_entries,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [LANES*OW-1:0] o_offset,
  output logic [LANES*RW-1:0] o_ram_addr,
  output logic [LANES*BW-1:0] o_to_branch,
  output logic [LANES-1:0]    o_lane_mask,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned NG = (MAX_ENTRIES + LANES - 1) / LANES;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [OW:0]   ZW  = (OW+1)'(EXPANSION_FACTOR);
  localparam logic [OW-1:0] ZM1 = OW'(EXPANSION_FACTOR - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         table_q [MAX_ENTRIES];
  logic [AW:0]           num_q, num_d, num_clamped;
  logic [GW-1:0]         group_q, group_d, group_nxt;
  logic [OW-1:0]         row_q, row_d, row_nxt;
  logic                  valid_q, valid_d;
  logic                  last_row, last_group, accept;
  logic                  cfg_ok, cfg_err_q;
  logic [LANES*OW-1:0]   offset_q, offset_d, beat_offset;
  logic [LANES*RW-1:0]   ram_q, ram_d, beat_ram;
  logic [LANES*BW-1:0]   branch_q, branch_d, beat_branch;
  logic [LANES-1:0]      mask_q, mask_d, beat_mask;
  logic [GW+BW-1:0]      lane_e;
  logic [DW-1:0]         lane_ent;
  logic [OW:0]           lane_sum;

  // A write is only legal while idle and with fields inside the table's value range.
  assign cfg_ok = (state_q == StIdle) &&
                  ({1'b0, i_cfg_data[OW+BW-1:BW]} < ZW) &&
                  ({1'b0, i_cfg_data[DW-1:OW+BW]} < (RW+1)'(NUM_RAMS));

  assign num_clamped = (i_num_entries > (AW+1)'(MAX_ENTRIES)) ? (AW+1)'(MAX_ENTRIES)
                                                               : i_num_entries;

  assign last_row   = (row_q == ZM1);
  assign last_group = ((32'(group_q) + 32'd1) * LANES) >= 32'(num_q);
  assign accept     = valid_q & i_ready;

  // Position of the beat to present next: the current one until the first load, then advanced.
  always_comb begin
    row_nxt   = row_q;
    group_nxt = group_q;
    if (valid_q) begin
      if (last_row) begin
        row_nxt   = '0;
        group_nxt = group_q + GW'(1);
      end else begin
        row_nxt = row_q + OW'(1);
      end
    end
  end

  // Lane contents for the next beat; lanes past the entry count are zeroed.
  always_comb begin
    beat_offset = '0;
    beat_ram    = '0;
    beat_branch = '0;
    beat_mask   = '0;
    lane_e      = '0;
    lane_ent    = '0;
    lane_sum    = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_e   = {group_nxt, BW'(k)};
      lane_ent = table_q[lane_e];
      lane_sum = {1'b0, lane_ent[OW+BW-1:BW]} + {1'b0, row_nxt};
      if (lane_sum >= ZW) lane_sum = lane_sum - ZW;
      if ((AW+1)'(lane_e) < num_q) begin
        beat_mask[k]             = 1'b1;
        beat_offset[k*OW +: OW]  = lane_sum[OW-1:0];
        beat_ram[k*RW +: RW]     = lane_ent[DW-1:OW+BW];
        beat_branch[k*BW +: BW]  = lane_ent[BW-1:0];
      end
    end
  end

  // Run control: start/abort, beat loading and completion.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    group_d  = group_q;
    row_d    = row_q;
    valid_d  = valid_q;
    offset_d = offset_q;
    ram_d    = ram_q;
    branch_d = branch_q;
    mask_d   = mask_q;
    if (i_abort) begin
      state_d  = StIdle;
      valid_d  = 1'b0;
      offset_d = '0;
      ram_d    = '0;
      branch_d = '0;
      mask_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            num_d   = num_clamped;
            group_d = '0;
            row_d   = '0;
            state_d = (num_clamped == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (!valid_q || accept) begin
            if (valid_q && last_row && last_group) begin
              state_d  = StDone;
              valid_d  = 1'b0;
              offset_d = '0;
              ram_d    = '0;
              branch_d = '0;
              mask_d   = '0;
            end else begin
              valid_d  = 1'b1;
              row_d    = row_nxt;
              group_d  = group_nxt;
              offset_d = beat_offset;
              ram_d    = beat_ram;
              branch_d = beat_branch;
              mask_d   = beat_mask;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and beat registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      num_q    <= '0;
      group_q  <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      offset_q <= '0;
      ram_q    <= '0;
      branch_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      group_q  <= group_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      offset_q <= offset_d;
      ram_q    <= ram_d;
      branch_q <= branch_d;
      mask_q   <= mask_d;
    end
  end

  // Entry table and write-reject pulse.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < MAX_ENTRIES; i++) table_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= i_cfg_we & ~cfg_ok;
      if (i_cfg_we && cfg_ok) table_q[i_cfg_addr] <= i_cfg_data;
    end
  end

  assign o_offset    = offset_q;
  assign o_ram_addr  = ram_q;
  assign o_to_branch = branch_q;
  assign o_lane_mask = mask_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q == StRun);
  assign o_done      = (state_q == StDone);
  assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_ldpc_forest_scheduler.sv
// Self-checking bench for ldpc_forest_scheduler against a table-walk reference model.
module tb_ldpc_forest_scheduler;

  localparam int Z  = 96;
  localparam int NR = 24;
  localparam int ME = 64;

  typedef struct packed {
    logic [55:0] off;
    logic [39:0] ram;
    logic [23:0] br;
    logic [7:0]  mask;
  } beat_t;

  logic        i_clock = 1'b0;
  logic        i_reset_n, i_cfg_we, i_start, i_abort, i_ready;
  logic [5:0]  i_cfg_addr;
  logic [14:0] i_cfg_data;
  logic [6:0]  i_num_entries;
  logic        o_cfg_err, o_valid, o_busy, o_done;
  logic [55:0] o_offset;
  logic [39:0] o_ram_addr;
  logic [23:0] o_to_branch;
  logic [7:0]  o_lane_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] model_tbl [ME];
  beat_t got[$];
  int first_valid, last_acc, done_cyc, done_cnt, stall_viol, extra_beats;
  bit timed_out;

  ldpc_forest_scheduler dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .o_cfg_err(o_cfg_err), .i_num_entries(i_num_entries),
    .i_start(i_start), .i_abort(i_abort), .o_offset(o_offset), .o_ram_addr(o_ram_addr),
    .o_to_branch(o_to_branch), .o_lane_mask(o_lane_mask), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.off = o_offset; b.ram = o_ram_addr; b.br = o_to_branch; b.mask = o_lane_mask;
    return b;
  endfunction

  function automatic int eff_num(int num);
    return (num > ME) ? ME : num;
  endfunction

  function automatic int exp_nbeats(int num);
    return ((eff_num(num) + 7) / 8) * Z;
  endfunction

  // Beat i of a run: group i/Z, row i%Z; lane k reads entry group*8+k.
  function automatic beat_t exp_beat(int i, int num);
    beat_t b;
    int g, r, e, sh;
    b = '0;
    g = i / Z;
    r = i % Z;
    for (int k = 0; k < 8; k++) begin
      e = g * 8 + k;
      if (e < eff_num(num)) begin
        sh = int'(model_tbl[e][9:3]);
        b.mask[k]        = 1'b1;
        b.off[k*7 +: 7]  = 7'((sh + r) % Z);
        b.ram[k*5 +: 5]  = model_tbl[e][14:10];
        b.br[k*3 +: 3]   = model_tbl[e][2:0];
      end
    end
    return b;
  endfunction

  task automatic cfg_write(input int addr, input int ram, input int sh, input int br,
                           input bit idle, output bit err, output bit exp_err);
    bit ok;
    ok = idle && (sh < Z) && (ram < NR);
    i_cfg_we = 1'b1; i_cfg_addr = 6'(addr); i_cfg_data = {5'(ram), 7'(sh), 3'(br)};
    tick();
    i_cfg_we = 1'b0;
    err = o_cfg_err;
    exp_err = !ok;
    if (ok) model_tbl[addr] = {5'(ram), 7'(sh), 3'(br)};
  endtask

  // Starts a run and records accepted beats; ready_mode 0 = always, 1 = toggle, 2 = random.
  task automatic collect_run(input int num, input int ready_mode, input bit hold_start,
                             input int max_cycles);
    beat_t snap;
    bit held;
    int tail;
    got.delete();
    first_valid = -1; last_acc = -1; done_cyc = -1; done_cnt = 0; stall_viol = 0;
    extra_beats = 0; timed_out = 0; tail = -1;
    i_num_entries = 7'(num);
    i_start = 1'b1;
    tick();
    if (!hold_start) i_start = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (ready_mode == 0) i_ready = 1'b1;
      else if (ready_mode == 1) i_ready = (c % 2 == 0);
      else i_ready = 1'($urandom % 2);
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        i_start = 1'b0;
        if (tail < 0) tail = 4;
      end
      if (o_valid && first_valid < 0) first_valid = c;
      if (o_valid && i_ready) begin
        if (tail >= 0) extra_beats++;
        else begin
          got.push_back(cur_beat());
          last_acc = c;
        end
      end
      held = o_valid && !i_ready;
      snap = cur_beat();
      tick();
      if (held && cur_beat() !== snap) stall_viol++;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    if (tail < 0) timed_out = 1'b1;
    i_ready = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({o_valid, o_busy, o_done, o_cfg_err, cur_beat()} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got %h required 0", {o_valid, o_busy, o_done, o_cfg_err, cur_beat()});
    end
    i_reset_n = 1'b1;
    tick();
    n_checks++;
    if ({o_valid, o_busy, o_done, o_cfg_err, cur_beat()} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h required 0", {o_valid, o_busy, o_done, o_cfg_err, cur_beat()});
    end
  endtask

  task automatic test_basic();
    bit err, xerr;
    beat_t xb;
    cfg_write(0, 5, 10, 2, 1'b1, err, xerr);
    n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL basic_cfg0: got %0b required %0b", err, xerr); end
    cfg_write(1, 0, 0, 7, 1'b1, err, xerr);
    n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL basic_cfg1: got %0b required %0b", err, xerr); end
    cfg_write(2, 23, 95, 0, 1'b1, err, xerr);
    n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL basic_cfg2: got %0b required %0b", err, xerr); end
    collect_run(3, 0, 1'b0, 300);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got no done required done"); end
    n_checks++; if (got.size() !== 96) begin n_fail++; $display("FAIL basic_nbeats: got %0d required 96", got.size()); end
    n_checks++; if (first_valid !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d required 1", first_valid); end
    n_checks++; if (done_cyc !== last_acc + 1) begin n_fail++; $display("FAIL basic_done_cyc: got %0d required %0d", done_cyc, last_acc + 1); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, 3);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL basic_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
    if (got.size() > 86) begin
      n_checks++; if (got[0].mask !== 8'h07) begin n_fail++; $display("FAIL basic_mask: got %h required 07", got[0].mask); end
      n_checks++; if (got[0].off[6:0] !== 7'd10) begin n_fail++; $display("FAIL basic_l0_first: got %0d required 10", got[0].off[6:0]); end
      n_checks++; if (got[86].off[6:0] !== 7'd0) begin n_fail++; $display("FAIL basic_l0_wrap: got %0d required 0", got[86].off[6:0]); end
      n_checks++; if (got[0].off[20:14] !== 7'd95) begin n_fail++; $display("FAIL basic_l2_first: got %0d required 95", got[0].off[20:14]); end
      n_checks++; if (got[1].off[20:14] !== 7'd0) begin n_fail++; $display("FAIL basic_l2_wrap: got %0d required 0", got[1].off[20:14]); end
    end
  endtask

  task automatic test_nine();
    bit err, xerr;
    beat_t xb;
    for (int a = 3; a < 9; a++) begin
      cfg_write(a, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, Z - 1)),
                int'($urandom_range(0, 7)), 1'b1, err, xerr);
      n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL nine_cfg%0d: got %0b required %0b", a, err, xerr); end
    end
    collect_run(9, 0, 1'b0, 400);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL nine_timeout: got no done required done"); end
    n_checks++; if (got.size() !== 192) begin n_fail++; $display("FAIL nine_nbeats: got %0d required 192", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, 9);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL nine_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
    if (got.size() == 192) begin
      n_checks++; if (got[95].mask !== 8'hFF) begin n_fail++; $display("FAIL nine_mask_g0: got %h required ff", got[95].mask); end
      n_checks++; if (got[96].mask !== 8'h01) begin n_fail++; $display("FAIL nine_mask_g1: got %h required 01", got[96].mask); end
    end
  endtask

  task automatic test_stall();
    int num;
    beat_t xb;
    num = int'($urandom_range(1, 8));
    collect_run(num, 1, 1'b0, 500);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout: got no done required done"); end
    n_checks++; if (got.size() !== 96) begin n_fail++; $display("FAIL stall_nbeats: got %0d required 96", got.size()); end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes required 0", stall_viol); end
    n_checks++;
    if (done_cyc < 190 || done_cyc > 200) begin
      n_fail++; $display("FAIL stall_done_cyc: got %0d required 190..200", done_cyc);
    end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, num);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL stall_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
  endtask

  task automatic test_cfg_err();
    bit err, xerr, seen;
    beat_t xb;
    cfg_write(0, 3, 96, 1, 1'b1, err, xerr);
    n_checks++; if (err !== 1'b1 || xerr !== 1'b1) begin n_fail++; $display("FAIL cfg_shift96: got %0b required 1", err); end
    tick();
    n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_pulse: got %0b required 0", o_cfg_err); end
    cfg_write(0, 24, 3, 1, 1'b1, err, xerr);
    n_checks++; if (err !== 1'b1 || xerr !== 1'b1) begin n_fail++; $display("FAIL cfg_ram24: got %0b required 1", err); end
    // Write and start in the same idle cycle: the run must see the new entry.
    i_cfg_we = 1'b1; i_cfg_addr = 6'd1; i_cfg_data = {5'd17, 7'd40, 3'd5};
    i_num_entries = 7'd2; i_start = 1'b1; i_ready = 1'b0;
    tick();
    model_tbl[1] = {5'd17, 7'd40, 3'd5};
    i_cfg_we = 1'b0; i_start = 1'b0;
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cfg_same_cycle_valid: got %0b required 1", o_valid); end
    xb = exp_beat(0, 2);
    n_checks++; if (cur_beat() !== xb) begin n_fail++; $display("FAIL cfg_same_cycle_beat: got %h required %h", cur_beat(), xb); end
    i_ready = 1'b1;
    cfg_write(0, 1, 1, 1, 1'b0, err, xerr);
    n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL cfg_in_run: got %0b required %0b", err, xerr); end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (o_done) seen = 1'b1;
      tick();
    end
    i_ready = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL cfg_drain: got no done required done"); end
    collect_run(2, 0, 1'b0, 300);
    n_checks++; if (got.size() !== 96) begin n_fail++; $display("FAIL cfg_rb_nbeats: got %0d required 96", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, 2);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL cfg_rb_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
  endtask

  task automatic test_zero();
    collect_run(0, 0, 1'b0, 20);
    n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL zero_nbeats: got %0d required 0", got.size()); end
    n_checks++; if (first_valid !== -1) begin n_fail++; $display("FAIL zero_valid: got cycle %0d required none", first_valid); end
    n_checks++; if (done_cyc !== 0) begin n_fail++; $display("FAIL zero_done_cyc: got %0d required 0", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_start_held();
    collect_run(2, 0, 1'b1, 300);
    n_checks++; if (got.size() !== 96) begin n_fail++; $display("FAIL held_nbeats: got %0d required 96", got.size()); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL held_done_cnt: got %0d required 1", done_cnt); end
    n_checks++; if (extra_beats !== 0) begin n_fail++; $display("FAIL held_extra: got %0d required 0", extra_beats); end
  endtask

  task automatic test_abort();
    int num, dc;
    beat_t xb;
    num = int'($urandom_range(9, 16));
    i_num_entries = 7'(num); i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (int'($urandom_range(3, 150))) tick();
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %0b required 1", o_busy); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0b required 0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b required 0", o_busy); end
    dc = 0;
    repeat (4) begin if (o_done) dc++; tick(); end
    n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", dc); end
    // Abort outranks start in the same idle cycle.
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_prio: got busy %0b required 0", o_busy); end
    collect_run(num, 0, 1'b0, 400);
    n_checks++; if (got.size() !== exp_nbeats(num)) begin n_fail++; $display("FAIL abort_rerun_nbeats: got %0d required %0d", got.size(), exp_nbeats(num)); end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, num);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL abort_rerun_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
  endtask

  task automatic test_reset_midrun();
    int dc;
    beat_t xb;
    i_num_entries = 7'd12; i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (int'($urandom_range(3, 150))) tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    n_checks++; if ({o_valid, o_busy, cur_beat()} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h required 0", {o_valid, o_busy, cur_beat()}); end
    tick();
    i_reset_n = 1'b1;
    for (int a = 0; a < ME; a++) model_tbl[a] = '0;
    dc = 0;
    repeat (3) begin if (o_done || o_valid) dc++; tick(); end
    n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", dc); end
    collect_run(8, 0, 1'b0, 300);
    n_checks++; if (got.size() !== 96) begin n_fail++; $display("FAIL rst_mid_nbeats: got %0d required 96", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      xb = exp_beat(i, 8);
      n_checks++;
      if (got[i] !== xb) begin n_fail++; $display("FAIL rst_mid_beat[%0d]: got %h required %h", i, got[i], xb); end
    end
  endtask

  task automatic test_random();
    bit err, xerr;
    int nums [2];
    beat_t xb;
    for (int a = 0; a < ME; a++) begin
      cfg_write(a, int'($urandom_range(0, 27)), int'($urandom_range(0, 99)),
                int'($urandom_range(0, 7)), 1'b1, err, xerr);
      n_checks++; if (err !== xerr) begin n_fail++; $display("FAIL rand_cfg%0d: got %0b required %0b", a, err, xerr); end
    end
    nums[0] = int'($urandom_range(1, 127));
    nums[1] = 100;
    for (int r = 0; r < 2; r++) begin
      collect_run(nums[r], 2, 1'b0, 5000);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout[%0d]: got no done required done", r); end
      n_checks++; if (got.size() !== exp_nbeats(nums[r])) begin n_fail++; $display("FAIL rand_nbeats[%0d]: got %0d required %0d", r, got.size(), exp_nbeats(nums[r])); end
      n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rand_hold[%0d]: got %0d changes required 0", r, stall_viol); end
      n_checks++; if (done_cyc !== last_acc + 1) begin n_fail++; $display("FAIL rand_done_cyc[%0d]: got %0d required %0d", r, done_cyc, last_acc + 1); end
      for (int i = 0; i < got.size(); i++) begin
        xb = exp_beat(i, nums[r]);
        n_checks++;
        if (got[i] !== xb) begin n_fail++; $display("FAIL rand_beat[%0d][%0d]: got %h required %h", r, i, got[i], xb); end
      end
    end
  endtask

  initial begin
    i_reset_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_num_entries = '0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    for (int a = 0; a < ME; a++) model_tbl[a] = '0;
    test_reset();
    test_basic();
    test_nine();
    test_stall();
    test_cfg_err();
    test_zero();
    test_start_held();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
